// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among NREQ writeback sources,
// with a registered write-port drive and a per-register pending-write scoreboard.
module rf_wb_arbiter #(
   parameter int NREQ        = 3,
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5,
   parameter int ADDR_SIZE   = 32
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [NREQ-1:0]             req_valid,
   output logic [NREQ-1:0]             req_ready,
   input  logic [NREQ*RFIDX_WIDTH-1:0] req_addr,
   input  logic [NREQ*XLEN-1:0]        req_data,
   input  logic [NREQ*ADDR_SIZE-1:0]   req_pc,
   input  logic                        alloc_valid,
   input  logic [RFIDX_WIDTH-1:0]      alloc_addr,
   input  logic [RFIDX_WIDTH-1:0]      rs1_addr,
   input  logic [RFIDX_WIDTH-1:0]      rs2_addr,
   output logic                        rs1_busy,
   output logic                        rs2_busy,
   output logic                        rf_write,
   output logic [RFIDX_WIDTH-1:0]      rf_waddr,
   output logic [XLEN-1:0]             rf_wdata,
   output logic [ADDR_SIZE-1:0]        rf_pc
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int NREGS = 1 << RFIDX_WIDTH;

   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       gnt_idx;
   logic                   gnt_found;
   logic [RFIDX_WIDTH-1:0] sel_addr;
   logic [XLEN-1:0]        sel_data;
   logic [ADDR_SIZE-1:0]   sel_pc;
   logic [NREGS-1:0]       busy;
   logic [NREGS-1:0]       busy_nxt;

   // Search starts just past the last winner so every source gets a turn.
   always_comb begin
      int cand;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      sel_addr  = '0;
      sel_data  = '0;
      sel_pc    = '0;
      cand      = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(rr_ptr) + k) % NREQ;
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = PTR_W'(cand);
            sel_addr  = req_addr[cand*RFIDX_WIDTH +: RFIDX_WIDTH];
            sel_data  = req_data[cand*XLEN +: XLEN];
            sel_pc    = req_pc[cand*ADDR_SIZE +: ADDR_SIZE];
         end
      end
      if (!rstn)
         gnt_found = 1'b0;
   end

   assign req_ready = gnt_found ? (NREQ'(1) << gnt_idx) : '0;

   // Alloc is applied after the clear so a same-register set wins.
   always_comb begin
      busy_nxt = busy;
      if (gnt_found && (sel_addr != '0))
         busy_nxt[sel_addr] = 1'b0;
      if (alloc_valid && (alloc_addr != '0))
         busy_nxt[alloc_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rr_ptr   <= PTR_W'(NREQ - 1);
         rf_write <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         rf_pc    <= '0;
         busy     <= '0;
      end else begin
         busy <= busy_nxt;
         if (gnt_found) begin
            rr_ptr   <= gnt_idx;
            rf_write <= (sel_addr != '0);
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
            rf_pc    <= sel_pc;
         end else begin
            rf_write <= 1'b0;
         end
      end
   end

   assign rs1_busy = busy[rs1_addr];
   assign rs2_busy = busy[rs2_addr];

endmodule
